// File: rtl/sram_req_adapter.sv
// Ready/valid request front-end for a single-port RW SRAM with one-cycle read latency.
// Read data lands in a small in-order response FIFO; request acceptance is credit-gated on FIFO space.
module sram_req_adapter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int RESP_DEPTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_en,
  output logic              mem_wmode,
  output logic              mem_wmask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = $clog2(RESP_DEPTH);

  logic [CW-1:0]     fifo_count;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              rd_inflight;
  logic [DATA_W-1:0] fifo_mem [RESP_DEPTH];
  logic [CW:0]       occupancy;
  logic              fire, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // An in-flight read already owns a FIFO slot, so it counts against credit.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, rd_inflight};
  assign req_ready = !reset && (occupancy < (CW+1)'(RESP_DEPTH));
  assign fire      = req_valid && req_ready;

  assign mem_en    = fire;
  assign mem_wmode = fire && req_write;
  assign mem_wmask = fire && req_write && req_wmask;
  assign mem_addr  = req_addr;
  assign mem_wdata = req_wdata;

  assign push       = rd_inflight;
  assign resp_valid = (fifo_count != '0);
  assign resp_rdata = fifo_mem[rd_ptr];
  assign pop        = resp_valid && resp_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rd_inflight <= 1'b0;
    end else begin
      rd_inflight <= fire && !req_write;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset; entries are only visible once counted.
  always_ff @(posedge clock) begin
    if (push && !reset) fifo_mem[wr_ptr] <= mem_rdata;
  end
endmodule

// File: tb/tb_sram_req_adapter.sv
// Scoreboard bench: reference memory updated at accept time, expected read data queued,
// negedge monitor pops on every response handshake and checks SRAM-side protocol.
module tb_sram_req_adapter;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int D  = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0, req_write = 1'b0, req_wmask = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, resp_valid, resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          mem_en, mem_wmode, mem_wmask;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  sram_req_adapter #(.ADDR_W(AW), .DATA_W(DW), .RESP_DEPTH(D)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .mem_en(mem_en), .mem_wmode(mem_wmode), .mem_wmask(mem_wmask),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // SRAM macro model: one-cycle read latency, write gated by mask bit.
  logic [DW-1:0] sram [1<<AW];
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_wmode) begin
        if (mem_wmask) sram[mem_addr] <= mem_wdata;
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  // resp_ready: fixed level or random per cycle
  bit rr_rand = 1'b0;
  bit rr_fixed = 1'b0;
  initial resp_ready = 1'b0;
  always @(posedge clock) begin
    #1 resp_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_fixed;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model and scoreboard
  logic [DW-1:0] ref_mem [1<<AW];
  logic [DW-1:0] exp_q[$];
  int            fcyc_q[$];
  int            last_lat = 0;
  bit            hold = 1'b0;
  logic [DW-1:0] hold_d;

  always @(negedge clock) begin
    if (reset) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_wmode", mem_wmode, 0);
      chk("rst_mem_wmask", mem_wmask, 0);
      exp_q.delete();
      fcyc_q.delete();
      hold = 1'b0;
    end else begin
      chk("fifo_bound", 32'(dut.fifo_count <= D), 1);
      chk("mem_en", mem_en, req_valid && req_ready);
      chk("mem_wmode", mem_wmode, req_valid && req_ready && req_write);
      chk("mem_wmask", mem_wmask, req_valid && req_ready && req_write && req_wmask);
      if (req_valid && req_ready) begin
        chk("mem_addr", mem_addr, req_addr);
        if (req_write) begin
          chk("mem_wdata", mem_wdata, req_wdata);
          if (req_wmask) ref_mem[req_addr] = req_wdata;
        end else begin
          exp_q.push_back(ref_mem[req_addr]);
          fcyc_q.push_back(cyc);
        end
      end
      if (hold) begin
        chk("hold_valid", resp_valid, 1);
        chk("hold_data", resp_rdata, hold_d);
      end
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_resp: got data %0h expected no response (cycle %0d)", resp_rdata, cyc);
        end else begin
          chk("resp_rdata", resp_rdata, exp_q.pop_front());
          last_lat = cyc - fcyc_q.pop_front();
          chk("min_latency", 32'(last_lat >= 2), 1);
        end
      end
      hold   = resp_valid && !resp_ready;
      hold_d = resp_rdata;
    end
  end

  task automatic issue(input bit w, input int a, input int d, input bit m);
    bit got = 1'b0;
    req_valid = 1'b1; req_write = w; req_addr = AW'(a); req_wdata = DW'(d); req_wmask = m;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock);
      got = req_ready;
      @(posedge clock);
      #1;
    end
    if (!got) chk("issue_timeout", 0, 1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    rr_rand = 1'b0;
    rr_fixed = 1'b1;
    for (int i = 0; i < 100 && (exp_q.size() != 0 || resp_valid); i++) @(posedge clock);
    repeat (3) @(posedge clock);
    #1;
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int seen, c0, c1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("ready_after_reset", req_ready, 1);
    @(posedge clock); #1;
    rr_fixed = 1'b1;

    // write then read of top address; exact two-cycle latency from empty
    issue(1, 'h3FF, 'hA5, 1);
    issue(0, 'h3FF, 0, 0);
    drain();
    chk("latency_top_addr", last_lat, 2);

    // masked-off write leaves old data
    issue(1, 5, 'h22, 1);
    issue(1, 5, 'h11, 0);
    issue(0, 5, 0, 0);
    drain();

    for (int i = 0; i < 4; i++) issue(1, i, 'h10 + i, 1);
    for (int i = 16; i < 32; i++) issue(1, i, int'($urandom_range(0, 255)), 1);

    // backpressure: credit runs out after two reads
    rr_fixed = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    issue(0, 0, 0, 0);
    issue(0, 1, 0, 0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(2);
    repeat (3) begin
      @(negedge clock);
      chk("ready_drop", req_ready, 0);
    end
    rr_fixed = 1'b1;
    issue(0, 2, 0, 0);
    issue(0, 3, 0, 0);
    drain();

    // reset in the cycle after a read fire discards it
    issue(0, 1, 0, 0);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("ready_post_reset", req_ready, 1);
    seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (resp_valid) seen++;
    end
    chk("no_resp_after_reset", seen, 0);
    @(posedge clock); #1;

    // streaming reads, always-ready consumer
    c0 = cyc;
    for (int i = 0; i < 40; i++)
      issue(0, ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(16, 31)), 0, 0);
    c1 = cyc;
    chk("stream_rate", 32'(2 * 40 >= c1 - c0), 1);
    drain();

    // random mixed traffic with random consumer stalls
    rr_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
      issue(1'($urandom_range(0, 1)), int'($urandom_range(16, 31)),
            int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sram_req_adapter.md
SRAM_REQ_ADAPTER -- requirements
Module: sram_req_adapter

Interface
REQ-001 Parameter ADDR_W, default 10, word address width.
REQ-002 Parameter DATA_W, default 8, data width.
REQ-003 Parameter RESP_DEPTH, default 2, response FIFO entries; legal range 2..8.
REQ-004 clock  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  adapter accepts request this cycle.
REQ-008 req_write  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  ADDR_W  word address.
REQ-010 req_wdata  input  DATA_W  write data.
REQ-011 req_wmask  input  1  write byte enable.
REQ-012 resp_valid  output  1  read data available.
REQ-013 resp_ready  input  1  consumer takes read data.
REQ-014 resp_rdata  output  DATA_W  read data.
REQ-015 mem_en, mem_wmode, mem_wmask  output  1 each  drive SRAM RW0_en, RW0_wmode, RW0_wmask.
REQ-016 mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; both drive SRAM RW0_addr and RW0_wdata.
REQ-017 mem_rdata  input  DATA_W  from SRAM RW0_rdata; valid only in the cycle after a read enable.

Function
REQ-018 Accept (fire) SHALL be req_valid && req_ready.
REQ-019 On fire: mem_en=1, mem_addr=req_addr, mem_wmode=req_write, mem_wdata=req_wdata, mem_wmask=req_write&&req_wmask, all combinational, same cycle.
REQ-020 Without fire: mem_en=0, mem_wmode=0, mem_wmask=0; mem_addr and mem_wdata are don't-care.
REQ-021 The adapter SHALL register a 1-bit rd_inflight flag: set by a read fire, cleared by default the next cycle.
REQ-022 In the cycle rd_inflight=1, mem_rdata SHALL be pushed into the response FIFO.
REQ-023 Read latency: a read fired in cycle N SHALL produce resp_valid=1 with its data in cycle N+2 at the earliest, when the FIFO is empty.
REQ-024 Responses SHALL return in request order; writes SHALL produce no response.
REQ-025 req_ready = (fifo_count + rd_inflight) < RESP_DEPTH, computed from registered state only.
REQ-026 req_ready SHALL have no combinational path from req_valid, req_write, or resp_ready.
REQ-027 The gating in REQ-025 SHALL apply to writes as well as reads.
REQ-028 resp_valid = (fifo_count != 0); resp_rdata = head entry, stable while resp_valid && !resp_ready.
REQ-029 Pop SHALL occur when resp_valid && resp_ready.
REQ-030 A push and a pop in the same cycle SHALL leave fifo_count unchanged and preserve order.
REQ-031 Push and pop pointers SHALL wrap modulo RESP_DEPTH.
REQ-032 The FIFO SHALL never overflow by construction; the bench asserts fifo_count <= RESP_DEPTH.
REQ-033 A pop in cycle N SHALL raise req_ready no earlier than cycle N+1.
REQ-034 A read and a write to the same address in consecutive cycles SHALL be issued in order; the read returns the old data if it is first, the new data if it is second.

Reset
REQ-035 While reset=1, the adapter SHALL force fifo_count=0, pointers=0, rd_inflight=0, resp_valid=0, req_ready=0, mem_en=0, mem_wmode=0, and mem_wmask=0.
REQ-036 A read in flight when reset asserts SHALL be discarded: no response is produced after reset.
REQ-037 In the first cycle after reset deasserts, req_ready SHALL be 1.
REQ-038 SRAM contents SHALL be unaffected by reset.

Verification
REQ-039 Write 0xA5 to address 0x3FF, then read 0x3FF with resp_ready=1 -> resp_valid 2 cycles after the read fire, resp_rdata=0xA5, no response for the write.
REQ-040 Write 0x11 with req_wmask=0 to address 5 (prior value 0x22), then read 5 -> 0x22 returned.
REQ-041 Issue back-to-back reads of addresses 0,1,2,3 (preloaded 0x10..0x13) with resp_ready=0 -> req_ready drops after 2 fires; raising resp_ready drains 0x10,0x11, then the remaining reads complete in order with 0x12,0x13.
REQ-042 Streaming reads with resp_ready=1 and RESP_DEPTH=2 -> sustained push and pop in the same cycle, no loss or duplication, at least 1 accept every 2 cycles, and fifo_count <= 2 throughout.
REQ-043 Assert reset for 1 cycle in the cycle after a read fire -> no resp_valid afterwards and req_ready=1 in the cycle after reset deasserts.
REQ-044 Random ready/valid traffic checked against a reference memory model -> all read data match, in order, with zero protocol violations.
